// File: rtl/acc_requant_if.sv
// acc_requant_if: handshake bundle between the accumulator source, the
// requantizer and the downstream sigmoid stage.
//   acc_valid_i / acc_ready_o : input vector handshake
//   acc_i  [N_COLS*ACC_W]     : signed accumulators, column c at [c*ACC_W +: ACC_W]
//   bias_i [N_COLS*OUT_W]     : signed per-column bias, same packing
//   z_valid_o / z_ready_i     : output beat handshake
//   z_o [OUT_W]               : signed saturated result
//   col_o                     : column index of z_o
//   last_o                    : high on the beat for column N_COLS-1
// Modports: slave = requantizer side, master = source/sink side.
interface acc_requant_if #(
  parameter int N_COLS = 4,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16
);
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic                      acc_valid_i;
  logic                      acc_ready_o;
  logic [N_COLS*ACC_W-1:0]   acc_i;
  logic [N_COLS*OUT_W-1:0]   bias_i;
  logic                      z_valid_o;
  logic                      z_ready_i;
  logic signed [OUT_W-1:0]   z_o;
  logic [COL_W-1:0]          col_o;
  logic                      last_o;

  modport slave (
    input  acc_valid_i, acc_i, bias_i, z_ready_i,
    output acc_ready_o, z_valid_o, z_o, col_o, last_o
  );

  modport master (
    output acc_valid_i, acc_i, bias_i, z_ready_i,
    input  acc_ready_o, z_valid_o, z_o, col_o, last_o
  );
endinterface

// File: rtl/acc_requant.sv
// acc_requant: captures one vector of N_COLS signed accumulators plus biases,
// then emits one requantized, saturated OUT_W value per column:
//   z = sat( (acc + (bias << SHIFT)) >>> SHIFT )
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : acc_requant_if.slave (input vector handshake, output beat handshake)
// Configuration macro:
//   ACC_REQUANT_ROUND_EN - when defined, adds 2^(SHIFT-1) before the shift
//                          (round half up); otherwise the shift truncates (floor).
//
// state | meaning
// IDLE  | waiting for a vector; ready only once the last beat has been taken
// DRAIN | vector captured, loading one column per accepted output slot
module acc_requant #(
  parameter int N_COLS = 4,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 8
) (
  input logic          clk,
  input logic          rst,
  acc_requant_if.slave bus
);
  localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int SUM_W = ACC_W + OUT_W + 1;

  localparam logic signed [SUM_W-1:0] MAX_V = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MIN_V = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t state_q, state_d;

  logic signed [ACC_W-1:0] acc_q  [N_COLS];
  logic signed [OUT_W-1:0] bias_q [N_COLS];
  logic [COL_W-1:0]        cnt_q;

  logic                    z_valid_q;
  logic signed [OUT_W-1:0] z_q;
  logic [COL_W-1:0]        col_q;
  logic                    last_q;

  logic ready;
  logic accept;
  logic load;
  logic pop;
  logic is_last;

  logic signed [ACC_W-1:0] acc_sel;
  logic signed [OUT_W-1:0] bias_sel;
  logic signed [SUM_W-1:0] acc_ext;
  logic signed [SUM_W-1:0] bias_sh;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sum_r;
  logic signed [SUM_W-1:0] q;
  logic signed [OUT_W-1:0] z_sat;

  // Ready is gated by rst so it reads low for the whole reset window.
  assign ready   = (state_q == IDLE) && !z_valid_q && !rst;
  assign pop     = z_valid_q && bus.z_ready_i;
  assign is_last = (cnt_q == COL_W'(N_COLS - 1));

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.acc_valid_i && ready) begin
          accept  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Output slot is free if empty or being consumed this cycle.
        if (!z_valid_q || bus.z_ready_i) begin
          load = 1'b1;
          if (is_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: the sum is wide enough that neither the bias shift nor the
  // rounding constant can overflow before saturation.
  always_comb begin
    acc_sel  = acc_q[cnt_q];
    bias_sel = bias_q[cnt_q];
    acc_ext  = {{(SUM_W-ACC_W){acc_sel[ACC_W-1]}}, acc_sel};
    bias_sh  = {{(SUM_W-OUT_W){bias_sel[OUT_W-1]}}, bias_sel} <<< SHIFT;
    sum      = acc_ext + bias_sh;
`ifdef ACC_REQUANT_ROUND_EN
    sum_r    = sum + (SUM_W'(1) <<< (SHIFT - 1));
`else
    sum_r    = sum;
`endif
    q        = sum_r >>> SHIFT;
    if (q > MAX_V)      z_sat = MAX_V[OUT_W-1:0];
    else if (q < MIN_V) z_sat = MIN_V[OUT_W-1:0];
    else                z_sat = q[OUT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      z_valid_q <= 1'b0;
      z_q       <= '0;
      col_q     <= '0;
      last_q    <= 1'b0;
      for (int c = 0; c < N_COLS; c++) begin
        acc_q[c]  <= '0;
        bias_q[c] <= '0;
      end
    end else begin
      if (accept) begin
        cnt_q <= '0;
        for (int c = 0; c < N_COLS; c++) begin
          acc_q[c]  <= bus.acc_i[c*ACC_W +: ACC_W];
          bias_q[c] <= bus.bias_i[c*OUT_W +: OUT_W];
        end
      end
      if (load) begin
        z_q       <= z_sat;
        col_q     <= cnt_q;
        last_q    <= is_last;
        z_valid_q <= 1'b1;
        cnt_q     <= is_last ? '0 : cnt_q + 1'b1;
      end else if (pop) begin
        z_valid_q <= 1'b0;
      end
    end
  end

  assign bus.acc_ready_o = ready;
  assign bus.z_valid_o   = z_valid_q;
  assign bus.z_o         = z_q;
  assign bus.col_o       = col_q;
  assign bus.last_o      = last_q;
endmodule

// File: tb/tb_acc_requant.sv
// tb_acc_requant: directed vector table plus hand-written stall, ignore and
// reset sequences for acc_requant (N_COLS=4, ACC_W=32, OUT_W=16, SHIFT=8).
// Expected values follow ACC_REQUANT_ROUND_EN when the bench is built with it.
module tb_acc_requant;
  localparam int N_COLS = 4;
  localparam int ACC_W  = 32;
  localparam int OUT_W  = 16;
  localparam int SHIFT  = 8;
`ifdef ACC_REQUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  acc_requant_if #(.N_COLS(N_COLS), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus ();

  acc_requant #(.N_COLS(N_COLS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [ACC_W-1:0] acc  [N_COLS];
    logic signed [OUT_W-1:0] bias [N_COLS];
    int                      exp  [N_COLS];
  } vec_t;

  vec_t vecs [4];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i,
                         input logic signed [ACC_W-1:0] a0, a1, a2, a3,
                         input logic signed [OUT_W-1:0] b0, b1, b2, b3,
                         input int e0, e1, e2, e3);
    vecs[i].acc[0] = a0;  vecs[i].acc[1] = a1;  vecs[i].acc[2] = a2;  vecs[i].acc[3] = a3;
    vecs[i].bias[0] = b0; vecs[i].bias[1] = b1; vecs[i].bias[2] = b2; vecs[i].bias[3] = b3;
    vecs[i].exp[0] = e0;  vecs[i].exp[1] = e1;  vecs[i].exp[2] = e2;  vecs[i].exp[3] = e3;
  endtask

  task automatic drive_vec(input int v);
    for (int c = 0; c < N_COLS; c++) begin
      bus.acc_i[c*ACC_W +: ACC_W]  = vecs[v].acc[c];
      bus.bias_i[c*OUT_W +: OUT_W] = vecs[v].bias[c];
    end
  endtask

  task automatic chk_beat(input string tag, input int v, input int c);
    chk($sformatf("%s c%0d valid", tag, c), int'(bus.z_valid_o), 1);
    chk($sformatf("%s c%0d col", tag, c), int'(bus.col_o), c);
    chk($sformatf("%s c%0d last", tag, c), int'(bus.last_o), (c == N_COLS-1) ? 1 : 0);
    chk($sformatf("%s c%0d z", tag, c), int'($signed(bus.z_o)), vecs[v].exp[c]);
  endtask

  task automatic wait_ready(input string tag);
    int guard = 0;
    while (!bus.acc_ready_o && guard < 50) begin
      step();
      guard++;
    end
    if (!bus.acc_ready_o) chk({tag, " ready timeout"}, 0, 1);
  endtask

  // Accept at edge T, beats at T+1..T+4, ready again after T+5.
  task automatic run_vector(input int v, input string tag);
    wait_ready(tag);
    drive_vec(v);
    bus.acc_valid_i = 1'b1;
    bus.z_ready_i   = 1'b1;
    step();
    bus.acc_valid_i = 1'b0;
    chk({tag, " T valid"}, int'(bus.z_valid_o), 0);
    chk({tag, " T ready"}, int'(bus.acc_ready_o), 0);
    for (int c = 0; c < N_COLS; c++) begin
      step();
      chk_beat(tag, v, c);
      chk($sformatf("%s c%0d ready", tag, c), int'(bus.acc_ready_o), 0);
    end
    step();
    chk({tag, " T+5 ready"}, int'(bus.acc_ready_o), 1);
    chk({tag, " T+5 valid"}, int'(bus.z_valid_o), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 384, -384, 32'sh7FFFFFFF, 32'sh80000000, 0, 0, 0, 0,
            RND ? 2 : 1, RND ? -1 : -2, 32767, -32768);
    set_vec(1, 0, 0, 256, -1, 1, -32768, -1, 0,
            1, -32768, 0, RND ? 0 : -1);
    set_vec(2, 1000, 255, 128, 127, 10, 0, 0, 0,
            RND ? 14 : 13, RND ? 1 : 0, RND ? 1 : 0, 0);
    set_vec(3, 8388352, 8388608, -8388608, -8388609, 0, 0, 0, 0,
            32767, 32767, -32768, -32768);

    rst             = 1'b1;
    bus.acc_valid_i = 1'b0;
    bus.z_ready_i   = 1'b0;
    bus.acc_i       = '0;
    bus.bias_i      = '0;
    step();
    step();
    chk("rst valid", int'(bus.z_valid_o), 0);
    chk("rst z", int'($signed(bus.z_o)), 0);
    chk("rst col", int'(bus.col_o), 0);
    chk("rst last", int'(bus.last_o), 0);
    chk("rst ready", int'(bus.acc_ready_o), 0);
    rst = 1'b0;
    step();
    chk("post-rst ready", int'(bus.acc_ready_o), 1);
    chk("post-rst valid", int'(bus.z_valid_o), 0);

    for (int v = 0; v < 4; v++) run_vector(v, $sformatf("vec%0d", v));

    // Stall on col 1 for 3 cycles while a second vector is offered and must be ignored.
    wait_ready("stall");
    drive_vec(2);
    bus.acc_valid_i = 1'b1;
    bus.z_ready_i   = 1'b1;
    step();
    drive_vec(0);
    step();
    chk_beat("stall", 2, 0);
    step();
    chk_beat("stall", 2, 1);
    bus.z_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_beat($sformatf("stall hold%0d", k), 2, 1);
      chk($sformatf("stall hold%0d ready", k), int'(bus.acc_ready_o), 0);
    end
    bus.z_ready_i = 1'b1;
    step();
    chk_beat("stall", 2, 2);
    step();
    chk_beat("stall", 2, 3);
    bus.acc_valid_i = 1'b0;
    step();
    chk("stall end valid", int'(bus.z_valid_o), 0);
    chk("stall end ready", int'(bus.acc_ready_o), 1);

    // Reset after col 1 has been accepted; remaining columns are discarded.
    drive_vec(0);
    bus.acc_valid_i = 1'b1;
    step();
    bus.acc_valid_i = 1'b0;
    step();
    chk_beat("mid-rst", 0, 0);
    step();
    chk_beat("mid-rst", 0, 1);
    step();
    chk_beat("mid-rst", 0, 2);
    rst = 1'b1;
    drive_vec(1);
    bus.acc_valid_i = 1'b1;
    step();
    chk("mid-rst valid", int'(bus.z_valid_o), 0);
    chk("mid-rst ready in rst", int'(bus.acc_ready_o), 0);
    chk("mid-rst col", int'(bus.col_o), 0);
    chk("mid-rst last", int'(bus.last_o), 0);
    chk("mid-rst z", int'($signed(bus.z_o)), 0);
    rst = 1'b0;
    bus.acc_valid_i = 1'b0;
    step();
    chk("after-rst ready", int'(bus.acc_ready_o), 1);
    chk("after-rst valid", int'(bus.z_valid_o), 0);
    run_vector(1, "after-rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
